// File: rtl/hazard_ctrl_param.sv
// rtl/hazard_ctrl_param.sv - pipeline hazard controller: forwarding selects, stall/flush, MDU busy tracking, stall counter
module hazard_ctrl_param #(
  parameter int AW     = 5,
  parameter int MD_LAT = 32,
  parameter int SCW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  RsD,
  input  logic [AW-1:0]  RtD,
  input  logic [AW-1:0]  RsE,
  input  logic [AW-1:0]  RtE,
  input  logic [AW-1:0]  WriteRegE,
  input  logic [AW-1:0]  WriteRegM,
  input  logic [AW-1:0]  WriteRegW,
  input  logic           RegWriteE,
  input  logic           RegWriteM,
  input  logic           RegWriteW,
  input  logic           MemtoRegE,
  input  logic           MemtoRegM,
  input  logic           BranchD,
  input  logic           MdStartE,
  input  logic           MdUseD,
  output logic [1:0]     ForwardAE,
  output logic [1:0]     ForwardBE,
  output logic           ForwardAD,
  output logic           ForwardBD,
  output logic           StallF,
  output logic           StallD,
  output logic           FlushE,
  output logic           MdBusy,
  output logic [SCW-1:0] StallCnt
);

  // Busy-counter width follows the latency; it is not a free parameter.
  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] MD_RELOAD = CW'(MD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [SCW-1:0] SC_ONE   = SCW'(1);

  // Register 0 is hard-wired to zero, so it never matches anything.
  function automatic logic match(input logic [AW-1:0] x, input logic [AW-1:0] y);
    return (x != '0) && (x == y);
  endfunction

  logic [CW-1:0]  mdcnt_q, mdcnt_d;
  logic [SCW-1:0] stallcnt_q, stallcnt_d;

  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall;

  // E-stage ALU operand forwarding; the younger M result wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (match(RsE, WriteRegM) && RegWriteM) begin
      ForwardAE = 2'b10;
    end else if (match(RsE, WriteRegW) && RegWriteW) begin
      ForwardAE = 2'b01;
    end
    if (match(RtE, WriteRegM) && RegWriteM) begin
      ForwardBE = 2'b10;
    end else if (match(RtE, WriteRegW) && RegWriteW) begin
      ForwardBE = 2'b01;
    end
  end

  // D-stage branch comparator forwarding; loaded data is not ready in M so it is never forwarded.
  always_comb begin
    ForwardAD = match(RsD, WriteRegM) && RegWriteM && !MemtoRegM;
    ForwardBD = match(RtD, WriteRegM) && RegWriteM && !MemtoRegM;
  end

  // Hazard detection; stall controls are suppressed while in reset.
  always_comb begin
    lwstall = MemtoRegE && RegWriteE &&
              (match(RsD, WriteRegE) || match(RtD, WriteRegE));
    brstall = BranchD &&
              ((RegWriteE && (match(RsD, WriteRegE) || match(RtD, WriteRegE))) ||
               (MemtoRegM && (match(RsD, WriteRegM) || match(RtD, WriteRegM))));
    mdstall = MdUseD && MdBusy;
    stall   = !rst && (lwstall || brstall || mdstall);
    StallF  = stall;
    StallD  = stall;
    FlushE  = stall;
  end

  // MDU busy counter: a start reloads it (even mid-operation), otherwise it runs down to zero.
  always_comb begin
    mdcnt_d = mdcnt_q;
    if (MdStartE) begin
      mdcnt_d = MD_RELOAD;
    end else if (mdcnt_q != '0) begin
      mdcnt_d = mdcnt_q - CNT_ONE;
    end
  end

  // Stall-cycle performance counter, saturating at all-ones.
  always_comb begin
    stallcnt_d = stallcnt_q;
    if (stall && (stallcnt_q != '1)) begin
      stallcnt_d = stallcnt_q + SC_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdcnt_q    <= '0;
      stallcnt_q <= '0;
    end else begin
      mdcnt_q    <= mdcnt_d;
      stallcnt_q <= stallcnt_d;
    end
  end

  // Status outputs.
  always_comb begin
    MdBusy   = (mdcnt_q != '0);
    StallCnt = stallcnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb/tb_hazard_ctrl_param.sv - randomized model-checked bench for hazard_ctrl_param
module tb_hazard_ctrl_param;

  localparam int AW    = 5;
  localparam int LAT_A = 4;
  localparam int SCW_A = 32;
  localparam int LAT_S = 5;
  localparam int SCW_S = 4;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MdStartE, MdUseD;

  logic [1:0] fae_a, fbe_a, fae_s, fbe_s;
  logic fad_a, fbd_a, fad_s, fbd_s;
  logic stf_a, std_a, fle_a, busy_a;
  logic stf_s, std_s, fle_s, busy_s;
  logic [SCW_A-1:0] cnt_a;
  logic [SCW_S-1:0] cnt_s;

  int total = 0;
  int bad   = 0;

  // model state
  int  cyc     = 0;
  int  start_a = -1000;
  int  start_s = -1000;
  longint mcnt_a = 0;
  longint mcnt_s = 0;

  always #5 clk = ~clk;

  hazard_ctrl_param #(.AW(AW), .MD_LAT(LAT_A), .SCW(SCW_A)) dut (
    .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdStartE(MdStartE), .MdUseD(MdUseD),
    .ForwardAE(fae_a), .ForwardBE(fbe_a), .ForwardAD(fad_a), .ForwardBD(fbd_a),
    .StallF(stf_a), .StallD(std_a), .FlushE(fle_a), .MdBusy(busy_a), .StallCnt(cnt_a)
  );

  hazard_ctrl_param #(.AW(AW), .MD_LAT(LAT_S), .SCW(SCW_S)) dut_s (
    .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdStartE(MdStartE), .MdUseD(MdUseD),
    .ForwardAE(fae_s), .ForwardBE(fbe_s), .ForwardAD(fad_s), .ForwardBD(fbd_s),
    .StallF(stf_s), .StallD(std_s), .FlushE(fle_s), .MdBusy(busy_s), .StallCnt(cnt_s)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit mt(input logic [AW-1:0] x, input logic [AW-1:0] y);
    return (x != 0) && (x == y);
  endfunction

  // MDU is busy during the LAT-1 cycles following the cycle in which it was started
  function automatic bit m_busy(input int start, input int lat);
    return (cyc - start >= 1) && (cyc - start <= lat - 1);
  endfunction

  function automatic bit m_stall(input bit busy);
    bit lw, br;
    if (rst) return 0;
    lw = MemtoRegE && RegWriteE && (mt(RsD, WriteRegE) || mt(RtD, WriteRegE));
    br = BranchD && ((RegWriteE && (mt(RsD, WriteRegE) || mt(RtD, WriteRegE))) ||
                     (MemtoRegM && (mt(RsD, WriteRegM) || mt(RtD, WriteRegM))));
    return lw || br || (MdUseD && busy);
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [AW-1:0] r);
    if (mt(r, WriteRegM) && RegWriteM) return 2'b10;
    if (mt(r, WriteRegW) && RegWriteW) return 2'b01;
    return 2'b00;
  endfunction

  // compare every output of both instances against the model, then advance one clock
  task automatic tick();
    bit ba, bs, sa, ss;
    logic [1:0] efa, efb;
    bit ead, ebd;
    #1;
    ba  = m_busy(start_a, LAT_A);
    bs  = m_busy(start_s, LAT_S);
    sa  = m_stall(ba);
    ss  = m_stall(bs);
    efa = m_fwd_e(RsE);
    efb = m_fwd_e(RtE);
    ead = mt(RsD, WriteRegM) && RegWriteM && !MemtoRegM;
    ebd = mt(RtD, WriteRegM) && RegWriteM && !MemtoRegM;
    chk("ForwardAE", fae_a, efa);
    chk("ForwardBE", fbe_a, efb);
    chk("ForwardAD", fad_a, ead);
    chk("ForwardBD", fbd_a, ebd);
    chk("ForwardAE_s", fae_s, efa);
    chk("ForwardBE_s", fbe_s, efb);
    chk("StallF", stf_a, sa);
    chk("StallD", std_a, sa);
    chk("FlushE", fle_a, sa);
    chk("MdBusy", busy_a, ba);
    chk("StallCnt", cnt_a, mcnt_a);
    chk("StallF_s", stf_s, ss);
    chk("FlushE_s", fle_s, ss);
    chk("MdBusy_s", busy_s, bs);
    chk("StallCnt_s", cnt_s, mcnt_s);
    @(posedge clk);
    if (rst) begin
      start_a = -1000;
      start_s = -1000;
      mcnt_a  = 0;
      mcnt_s  = 0;
    end else begin
      if (sa && mcnt_a < (64'd1 << SCW_A) - 1) mcnt_a++;
      if (ss && mcnt_s < (64'd1 << SCW_S) - 1) mcnt_s++;
      if (MdStartE) begin
        start_a = cyc;
        start_s = cyc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_in();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; MdStartE = 0; MdUseD = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    clear_in();
    rst = 1;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    #1;
    chk("lit_reset_cnt", cnt_a, 0);
    chk("lit_reset_busy", busy_a, 0);
    chk("lit_reset_stall", stf_a, 0);

    // forwarding priority
    RsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
    #1 chk("lit_fwd_m", fae_a, 2'b10);
    tick();
    RegWriteM = 0;
    #1 chk("lit_fwd_w", fae_a, 2'b01);
    tick();
    RsE = 0;
    #1 chk("lit_fwd_r0", fae_a, 2'b00);
    tick();
    clear_in();

    // load-use
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
    #1 chk("lit_lw_stall", {stf_a, std_a, fle_a}, 3'b111);
    tick();
    #1 chk("lit_lw_cnt", cnt_a, 1);
    RtD = 0;
    #1 chk("lit_lw_r0", stf_a, 0);
    tick();
    clear_in();

    // branch dependency
    BranchD = 1; RsD = 5; RegWriteE = 1; WriteRegE = 5;
    #1 chk("lit_br_e", stf_a, 1);
    tick();
    RegWriteE = 0; WriteRegE = 0; WriteRegM = 5; RegWriteM = 1;
    #1 chk("lit_br_fwd", {fad_a, stf_a}, 2'b10);
    tick();
    MemtoRegM = 1;
    #1 chk("lit_br_load", {fad_a, stf_a}, 2'b01);
    tick();
    clear_in();

    // MDU busy window with dependent instruction waiting
    do_reset();
    MdStartE = 1; MdUseD = 1;
    #1 chk("lit_md_start", {busy_a, stf_a}, 2'b00);
    tick();
    MdStartE = 0;
    for (int i = 0; i < LAT_A - 1; i++) begin
      #1 chk("lit_md_busy", {busy_a, stf_a}, 2'b11);
      tick();
    end
    #1 chk("lit_md_release", {busy_a, stf_a}, 2'b00);
    chk("lit_md_cnt", cnt_a, 3);
    MdUseD = 0;
    tick();

    // reset in the middle of an MDU operation
    MdStartE = 1;
    tick();
    MdStartE = 0;
    tick();
    #1 chk("lit_md_mid", busy_a, 1);
    do_reset();
    #1 chk("lit_rst_busy", busy_a, 0);
    chk("lit_rst_cnt", cnt_a, 0);
    chk("lit_rst_cnt_s", cnt_s, 0);

    // saturation on the narrow-counter instance
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
    for (int i = 0; i < 20; i++) tick();
    #1 chk("lit_sat_s", cnt_s, 15);
    chk("lit_sat_a", cnt_a, 20);
    clear_in();
    tick();

    // randomized traffic with small register space to provoke matches
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      RsD       = AW'($urandom_range(0, 3));
      RtD       = AW'($urandom_range(0, 3));
      RsE       = AW'($urandom_range(0, 3));
      RtE       = AW'($urandom_range(0, 3));
      WriteRegE = AW'($urandom_range(0, 3));
      WriteRegM = AW'($urandom_range(0, 3));
      WriteRegW = AW'($urandom_range(0, 3));
      RegWriteE = 1'($urandom);
      RegWriteM = 1'($urandom);
      RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);
      MemtoRegM = 1'($urandom);
      BranchD   = 1'($urandom);
      MdStartE  = ($urandom_range(0, 9) == 0);
      MdUseD    = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
Parametrised hazard controller for the 5-stage pipeline. It generates the E-stage ALU-operand forwarding selects and the D-stage branch-comparator forwarding selects. It also detects load-use and branch-dependency stalls, tracks a multi-cycle multiply/divide unit (MDU) with a busy counter, and counts stall cycles for performance monitoring. It sits beside the datapath and drives the F/D stall and E flush controls.

Parameters:
AW, 5, register-address width
MD_LAT, 32, MDU latency in cycles counting the E-stage start cycle; legal range 2..255
CW, $clog2(MD_LAT), busy-counter width (derived, not overridable)
SCW, 32, stall-counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
RsD  in  AW  D-stage source A
RtD  in  AW  D-stage source B
RsE  in  AW  E-stage source A
RtE  in  AW  E-stage source B
WriteRegE  in  AW  E-stage destination
WriteRegM  in  AW  M-stage destination
WriteRegW  in  AW  W-stage destination
RegWriteE  in  1  E-stage register write enable
RegWriteM  in  1  M-stage register write enable
RegWriteW  in  1  W-stage register write enable
MemtoRegE  in  1  E-stage instruction is a load
MemtoRegM  in  1  M-stage instruction is a load
BranchD  in  1  D-stage instruction is a branch
MdStartE  in  1  E-stage instruction starts an MDU op
MdUseD  in  1  D-stage instruction reads HI/LO or starts an MDU op
ForwardAE  out  2  00 regfile, 01 W result, 10 M ALU result
ForwardBE  out  2  same encoding as ForwardAE
ForwardAD  out  1  1 = forward M ALU result to branch operand A
ForwardBD  out  1  1 = forward M ALU result to branch operand B
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
FlushE  out  1  clear ID/EX register (insert bubble)
MdBusy  out  1  MDU in progress
StallCnt  out  SCW  stall-cycle counter

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- match(x,y) = (x != 0) && (x == y). Register 0 is never forwarded and never causes a stall.
- ForwardAE:
  - 10 if match(RsE,WriteRegM) && RegWriteM.
  - Otherwise 01 if match(RsE,WriteRegW) && RegWriteW.
  - Otherwise 00.
  - M has priority over W when both match.
- ForwardBE: identical to ForwardAE, using RtE.
- ForwardAD = match(RsD,WriteRegM) && RegWriteM && !MemtoRegM. ForwardBD is the same, using RtD. Load data is never forwarded from M to D.
- lwstall = MemtoRegE && RegWriteE && (match(RsD,WriteRegE) || match(RtD,WriteRegE)).
- brstall = BranchD && any of the following:
  - RegWriteE && (match(RsD,WriteRegE) || match(RtD,WriteRegE)).
  - MemtoRegM && (match(RsD,WriteRegM) || match(RtD,WriteRegM)).
- mdstall = MdUseD && MdBusy.
- stall = lwstall | brstall | mdstall. StallF = StallD = FlushE = stall, combinational, same cycle.
- While rst=1, stall outputs are forced to 0. Forward outputs stay purely combinational.
- MDU counter mdcnt (CW bits):
  - Reset value 0.
  - On a clock edge with MdStartE=1: mdcnt <= MD_LAT-1. This also applies while busy (restart/reload; not expected because mdstall blocks it).
  - Otherwise, if mdcnt != 0: mdcnt <= mdcnt-1.
  - MdBusy = (mdcnt != 0). MdBusy is therefore high for exactly MD_LAT-1 cycles after the start cycle.
  - A dependent D instruction issues in the cycle MdBusy falls.
- MdStartE is accepted even when FlushE=1 in the same cycle. FlushE bubbles the incoming instruction, not the one currently in E.
- StallCnt:
  - Reset value 0.
  - Increments by 1 on every edge where stall=1 and rst=0.
  - Saturates at all-ones; no wrap.
- Reset mid-MDU-operation: mdcnt clears at that edge and MdBusy drops in the following cycle.
- All outputs after reset: Forward* reflect inputs; StallF/StallD/FlushE 0 (absent new hazards); MdBusy 0; StallCnt 0.

Test Plan:
- RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> ForwardAE=10. Then drop RegWriteM -> ForwardAE=01. Then RsE=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RegWriteE=1, WriteRegE=8, RtD=8 -> StallF=StallD=FlushE=1 for one cycle; StallCnt increments 0->1. With RtD=0 instead -> no stall.
- Branch: BranchD=1, RsD=5, RegWriteE=1, WriteRegE=5 -> stall. Next cycle M holds reg 5 as ALU result -> ForwardAD=1, no stall. If that M-stage instruction is a load (MemtoRegM=1) -> stall, ForwardAD=0.
- MD_LAT=4: MdStartE pulse at edge 0 -> MdBusy high for 3 cycles. MdUseD=1 held throughout -> stall for those 3 cycles, released in the cycle MdBusy falls; StallCnt=3.
- MDU in progress (mdcnt=2), assert rst for one edge -> MdBusy=0 the next cycle and StallCnt=0.
- Force StallCnt near saturation (SCW=4 build, 20 stall cycles) -> StallCnt holds at 15.
